// File: rtl/mux_scan.sv
// rtl/mux_scan.sv - N-channel registered mux with manual select and dwell-based channel scan.
// Optional macro MUX_SCAN_CH_MASK_EN adds ch_mask to skip disabled channels.
module mux_scan #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 20,
  parameter int DWELL_W  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      auto,
  input  logic                      hold,
`ifdef MUX_SCAN_CH_MASK_EN
  input  logic [CHANNELS-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]          dout,
  output logic [SEL_W-1:0]          dout_ch,
  output logic                      dout_valid,
  output logic                      wrap
);

  typedef enum logic {MANUAL, SCAN} mode_t;

  mode_t               mode, mode_next;
  logic [SEL_W-1:0]    ptr, ptr_next;
  logic [DWELL_W-1:0]  cnt, cnt_next;
  logic [WIDTH-1:0]    dout_next;
  logic [SEL_W-1:0]    ch_next;
  logic                valid_next, wrap_next;

  logic [CHANNELS-1:0] en;
  logic [SEL_W-1:0]    adv_ptr;
  logic                adv_wrap;
  logic                found;

`ifdef MUX_SCAN_CH_MASK_EN
  assign en = ch_mask;
`else
  assign en = '1;
`endif

  // Shifts instead of indexed selects keep index widths independent of SEL_W.
  function automatic logic ch_enabled(input logic [CHANNELS-1:0] m, input int k);
    logic [CHANNELS-1:0] s;
    s = m >> k;
    return s[0];
  endfunction

  function automatic logic [WIDTH-1:0] pick(input logic [CHANNELS*WIDTH-1:0] d, input int k);
    logic [CHANNELS*WIDTH-1:0] s;
    s = d >> (k * WIDTH);
    return s[WIDTH-1:0];
  endfunction

  // Next enabled channel above ptr, wrapping past CHANNELS-1; found=0 means none enabled.
  always_comb begin
    adv_ptr  = ptr;
    adv_wrap = 1'b0;
    found    = 1'b0;
    for (int i = 1; i <= CHANNELS; i++) begin
      if (!found) begin
        if (int'(ptr) + i < CHANNELS) begin
          if (ch_enabled(en, int'(ptr) + i)) begin
            found   = 1'b1;
            adv_ptr = SEL_W'(int'(ptr) + i);
          end
        end else if (ch_enabled(en, int'(ptr) + i - CHANNELS)) begin
          found    = 1'b1;
          adv_ptr  = SEL_W'(int'(ptr) + i - CHANNELS);
          adv_wrap = 1'b1;
        end
      end
    end
  end

  always_comb begin
    mode_next  = auto ? SCAN : MANUAL;
    ptr_next   = ptr;
    cnt_next   = cnt;
    ch_next    = ptr;
    valid_next = 1'b0;
    dout_next  = '0;
    wrap_next  = 1'b0;
    if (auto) begin
      if (mode == MANUAL) begin
        // Scan resumes from the channel the host was last looking at.
        ptr_next = dout_valid ? dout_ch : '0;
        cnt_next = '0;
      end else if (!hold) begin
        if (cnt == DWELL_W'(DWELL - 1)) begin
          cnt_next = '0;
          if (found) begin
            ptr_next  = adv_ptr;
            wrap_next = adv_wrap;
          end
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ch_next    = ptr_next;
      valid_next = ch_enabled(en, int'(ptr_next));
      dout_next  = valid_next ? pick(din, int'(ptr_next)) : '0;
    end else begin
      cnt_next   = '0;
      ch_next    = sel_in;
      valid_next = (int'(sel_in) < CHANNELS) && ch_enabled(en, int'(sel_in));
      dout_next  = valid_next ? pick(din, int'(sel_in)) : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode       <= MANUAL;
      ptr        <= '0;
      cnt        <= '0;
      dout       <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      mode       <= mode_next;
      ptr        <= ptr_next;
      cnt        <= cnt_next;
      dout       <= dout_next;
      dout_ch    <= ch_next;
      dout_valid <= valid_next;
      wrap       <= wrap_next;
    end
  end

endmodule

// File: tb/tb_mux_scan.sv
// tb/tb_mux_scan.sv - bench for mux_scan: 8-channel DWELL=4 and 6-channel DWELL=1 instances.
module tb_mux_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] din8;
  logic [47:0] din6;
  logic [2:0]  sel;
  logic        auto_s, hold_s;
  logic [7:0]  d8_dout, d6_dout;
  logic [2:0]  d8_ch, d6_ch;
  logic        d8_valid, d6_valid, d8_wrap, d6_wrap;
`ifdef MUX_SCAN_CH_MASK_EN
  logic [7:0]  mask8 = 8'hFF;
  logic [5:0]  mask6 = 6'h3F;
`endif

  always #5 clk = ~clk;

  mux_scan #(.WIDTH(8), .CHANNELS(8), .SEL_W(3), .DWELL(4), .DWELL_W(2)) dut8 (
    .clk(clk), .rst(rst), .din(din8), .sel_in(sel), .auto(auto_s), .hold(hold_s),
`ifdef MUX_SCAN_CH_MASK_EN
    .ch_mask(mask8),
`endif
    .dout(d8_dout), .dout_ch(d8_ch), .dout_valid(d8_valid), .wrap(d8_wrap));

  mux_scan #(.WIDTH(8), .CHANNELS(6), .SEL_W(3), .DWELL(1), .DWELL_W(1)) dut6 (
    .clk(clk), .rst(rst), .din(din6), .sel_in(sel), .auto(auto_s), .hold(hold_s),
`ifdef MUX_SCAN_CH_MASK_EN
    .ch_mask(mask6),
`endif
    .dout(d6_dout), .dout_ch(d6_ch), .dout_valid(d6_valid), .wrap(d6_wrap));

  // Reference: output after each edge, derived from the behavioural rules directly.
  typedef struct {
    bit scan;
    int ptr;
    int cnt;
    int dout;
    int ch;
    bit valid;
    bit wrap;
  } model_t;

  typedef struct {
    logic [2:0] sel;
    logic [7:0] e8;
    logic [7:0] e6;
    logic       v6;
  } vec_t;

  model_t m8, m6;
  int     tests = 0;
  int     fails = 0;

  function automatic model_t mreset();
    model_t r;
    r.scan = 0; r.ptr = 0; r.cnt = 0; r.dout = 0; r.ch = 0; r.valid = 0; r.wrap = 0;
    return r;
  endfunction

  function automatic model_t step(model_t s, int nch, int dw, bit a, bit h, int sl, logic [63:0] d);
    model_t n;
    n = s;
    n.wrap = 0;
    if (a) begin
      if (!s.scan) begin
        n.ptr = s.valid ? s.ch : 0;
        n.cnt = 0;
      end else if (!h) begin
        if (s.cnt == dw - 1) begin
          n.cnt  = 0;
          n.ptr  = (s.ptr + 1) % nch;
          n.wrap = (n.ptr == 0);
        end else begin
          n.cnt = s.cnt + 1;
        end
      end
      n.ch    = n.ptr;
      n.valid = 1;
      n.dout  = int'((d >> (8 * n.ptr)) & 64'hFF);
    end else begin
      n.cnt   = 0;
      n.ch    = sl;
      n.valid = (sl < nch);
      n.dout  = n.valid ? int'((d >> (8 * sl)) & 64'hFF) : 0;
    end
    n.scan = a;
    return n;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    cmp("model8", {19'h0, d8_dout, d8_ch, d8_valid, d8_wrap},
        {19'h0, 8'(m8.dout), 3'(m8.ch), m8.valid, m8.wrap});
    cmp("model6", {19'h0, d6_dout, d6_ch, d6_valid, d6_wrap},
        {19'h0, 8'(m6.dout), 3'(m6.ch), m6.valid, m6.wrap});
  endtask

  task automatic tick(input bit chk);
    m8 = step(m8, 8, 4, auto_s, hold_s, int'(sel), din8);
    m6 = step(m6, 6, 1, auto_s, hold_s, int'(sel), {16'h0, din6});
    @(posedge clk);
    @(negedge clk);
    if (chk) check_model();
  endtask

  vec_t tbl[8];

  initial begin
    int wraps;
    logic [7:0] v;
    for (int k = 0; k < 8; k++) begin
      tbl[k].sel = 3'(k);
      tbl[k].e8  = 8'(8'h10 + k);
      tbl[k].e6  = (k < 6) ? 8'(8'h20 + k) : 8'h00;
      tbl[k].v6  = (k < 6);
    end

    rst = 1'b1; auto_s = 1'b0; hold_s = 1'b0; sel = 3'd0;
    for (int k = 0; k < 8; k++) din8[k*8 +: 8] = 8'(8'h10 + k);
    for (int k = 0; k < 6; k++) din6[k*8 +: 8] = 8'(8'h20 + k);
    m8 = mreset(); m6 = mreset();
    @(negedge clk);
    cmp("reset_state8", {19'h0, d8_dout, d8_ch, d8_valid, d8_wrap}, 32'h0);
    cmp("reset_state6", {19'h0, d6_dout, d6_ch, d6_valid, d6_wrap}, 32'h0);
    rst = 1'b0;

    // Manual sweep; the 6-channel instance must reject selects 6 and 7.
    for (int k = 0; k < 8; k++) begin
      sel = tbl[k].sel;
      tick(1);
      cmp("sweep8_dout", 32'(d8_dout), 32'(tbl[k].e8));
      cmp("sweep8_valid", 32'(d8_valid), 32'h1);
      cmp("sweep6_dout", 32'(d6_dout), 32'(tbl[k].e6));
      cmp("sweep6_valid", 32'(d6_valid), 32'(tbl[k].v6));
    end

    // Asynchronous reset in the middle of a high clock phase.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    cmp("async_rst8", {19'h0, d8_dout, d8_ch, d8_valid, d8_wrap}, 32'h0);
    cmp("async_rst6", {19'h0, d6_dout, d6_ch, d6_valid, d6_wrap}, 32'h0);
    m8 = mreset(); m6 = mreset();
    sel = 3'd3;
    din8[31:24] = 8'hBB;
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    cmp("post_rst_dout", 32'(d8_dout), 32'hBB);
    cmp("post_rst_ch", 32'(d8_ch), 32'd3);
    cmp("post_rst_valid", 32'(d8_valid), 32'h1);
    din8[31:24] = 8'h13;

    // Full scan: each channel held four cycles, a single wrap on return to 0.
    sel = 3'd0;
    tick(1);
    auto_s = 1'b1;
    wraps = 0;
    for (int i = 0; i <= 32; i++) begin
      tick(1);
      cmp("scan_ch", 32'(d8_ch), 32'((i / 4) % 8));
      cmp("scan_wrap", 32'(d8_wrap), 32'(i == 32));
      wraps += int'(d8_wrap);
    end
    cmp("scan_wrap_count", 32'(wraps), 32'd1);

    // Reach channel 5 with cnt=2, then hold while channel 5 data changes.
    for (int i = 0; i < 22; i++) tick(1);
    cmp("pre_hold_ch", 32'(d8_ch), 32'd5);
    hold_s = 1'b1;
    for (int i = 0; i < 10; i++) begin
      v = 8'($urandom);
      din8[47:40] = v;
      tick(1);
      cmp("hold_dout", 32'(d8_dout), 32'(v));
      cmp("hold_ch", 32'(d8_ch), 32'd5);
    end
    hold_s = 1'b0;
    tick(1);
    cmp("release_ch5", 32'(d8_ch), 32'd5);
    tick(1);
    cmp("release_ch6", 32'(d8_ch), 32'd6);

    // Drop auto on the edge where channel 7 would wrap back to 0.
    for (int i = 0; i < 7; i++) tick(1);
    cmp("race_pre_ch", 32'(d8_ch), 32'd7);
    auto_s = 1'b0;
    sel = 3'd2;
    tick(1);
    cmp("race_ch", 32'(d8_ch), 32'd2);
    cmp("race_wrap", 32'(d8_wrap), 32'h0);
    cmp("race_valid", 32'(d8_valid), 32'h1);

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) auto_s = ~auto_s;
      hold_s = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) sel = 3'($urandom_range(0, 7));
      din8 = {$urandom, $urandom};
      din6 = {16'($urandom), $urandom};
      tick(1);
    end

`ifdef MUX_SCAN_CH_MASK_EN
    begin
      int seq[5] = '{0, 2, 5, 7, 0};
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      auto_s = 1'b0; hold_s = 1'b0; sel = 3'd0;
      mask8 = 8'b1010_0101;
      tick(0);
      auto_s = 1'b1;
      for (int i = 0; i < 17; i++) begin
        tick(0);
        cmp("mask_ch", 32'(d8_ch), 32'(seq[i / 4]));
        cmp("mask_wrap", 32'(d8_wrap), 32'(i == 16));
      end
      mask8 = 8'h00;
      tick(0);
      cmp("mask_none_valid", 32'(d8_valid), 32'h0);
      cmp("mask_none_dout", 32'(d8_dout), 32'h0);
      mask8 = 8'hFF;
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
